// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender with valid/ready handshake and 2-entry skid.
// Optional CSR zimm decode enabled by defining IMM_EXT_ZIMM_EN.
module imm_ext_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [31:0]      out_inst,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] T_I    = 3'b000;
    localparam logic [2:0] T_S    = 3'b001;
    localparam logic [2:0] T_B    = 3'b010;
    localparam logic [2:0] T_U    = 3'b011;
    localparam logic [2:0] T_J    = 3'b100;
    localparam logic [2:0] T_Z    = 3'b101;
    localparam logic [2:0] T_NONE = 3'b111;

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [2:0]       typ;
        logic [31:0]      inst;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state_q, state_d;
    logic   in_ready_q;
    entry_t main_q, skid_q, dec;
    logic   load_main, load_skid, skid_to_main;
    logic   accept, drain;

    logic [XLEN-1:0] imm_i;

    assign imm_i = XLEN'($signed(in_inst[31:20]));

    // Decode the immediate format from the opcode and extend to XLEN.
    always_comb begin
        dec      = '0;
        dec.typ  = T_NONE;
        dec.inst = in_inst;
        dec.tag  = in_tag;
        unique case (in_inst[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111: begin
                dec.typ = T_I;
                dec.imm = imm_i;
            end
            7'b1110011: begin
`ifdef IMM_EXT_ZIMM_EN
                if (in_inst[14]) begin
                    dec.typ = T_Z;
                    dec.imm = XLEN'(in_inst[19:15]);
                end else begin
                    dec.typ = T_I;
                    dec.imm = imm_i;
                end
`else
                dec.typ = T_I;
                dec.imm = imm_i;
`endif
            end
            7'b0011011: begin
                // OP-IMM-32 only exists on RV64.
                if (XLEN == 64) begin
                    dec.typ = T_I;
                    dec.imm = imm_i;
                end
            end
            7'b0100011: begin
                dec.typ = T_S;
                dec.imm = XLEN'($signed({in_inst[31:25],
                                         in_inst[11:7]}));
            end
            7'b1100011: begin
                dec.typ = T_B;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[7],
                                         in_inst[30:25],
                                         in_inst[11:8], 1'b0}));
            end
            7'b0110111,
            7'b0010111: begin
                dec.typ = T_U;
                dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
            end
            7'b1101111: begin
                dec.typ = T_J;
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12],
                                         in_inst[20], in_inst[30:21],
                                         1'b0}));
            end
            default: begin
                dec.typ = T_NONE;
                dec.imm = '0;
            end
        endcase
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_ready & (state_q != EMPTY);

    // Next-state and register-steering for main/skid entries.
    always_comb begin
        state_d      = state_q;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    load_main = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end else if (accept) begin
                    load_skid = 1'b1;
                    state_d   = FULL;
                end
            end
            FULL: begin
                if (out_ready) begin
                    skid_to_main = 1'b1;
                    state_d      = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // State register; in_ready is registered as "skid not occupied".
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    // Payload registers for main output and skid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            main_q.typ <= T_NONE;
            skid_q     <= '0;
            skid_q.typ <= T_NONE;
        end else begin
            if (load_main) begin
                main_q <= dec;
            end else if (skid_to_main) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign out_imm   = main_q.imm;
    assign out_type  = main_q.typ;
    assign out_inst  = main_q.inst;
    assign out_tag   = main_q.tag;

endmodule
